// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit: radix-2 Booth multiply, restoring divide on magnitudes.
// Optional divide-by-zero exception path enabled by defining MULTDIV_DIV0_EXC_EN.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multControl,
    input  logic             divControl,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

    state_t                  state;
    logic [5:0]              cnt;
    logic                    last_iter;

    logic signed [WIDTH-1:0] mcand;
    logic signed [WIDTH:0]   acc, acc_sum, acc_n, mext;
    logic [WIDTH-1:0]        mq, mq_n;
    logic                    qm1;

    logic [WIDTH-1:0]        rem, quot, dvs, rem_n, quot_n;
    logic [WIDTH:0]          rem_sh;
    logic                    trial_neg;
    logic                    sign_a, sign_b;

`ifdef MULTDIV_DIV0_EXC_EN
    logic                    div0_r;
    assign div0 = div0_r;
`else
    assign div0 = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] negate_if(input logic cond, input logic [WIDTH-1:0] v);
        return cond ? WIDTH'(-v) : v;
    endfunction

    // Accumulator carries one guard bit so subtracting the most negative multiplicand cannot overflow.
    assign mext      = {mcand[WIDTH-1], mcand};
    assign last_iter = (cnt == 6'(WIDTH - 1));

    always_comb begin
        acc_sum = acc;
        case ({mq[0], qm1})
            2'b01:   acc_sum = acc + mext;
            2'b10:   acc_sum = acc - mext;
            default: acc_sum = acc;
        endcase
        acc_n = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
        mq_n  = {acc_sum[0], mq[WIDTH-1:1]};

        // A zero divisor never yields a negative trial, so the quotient fills with ones.
        rem_sh    = {rem, quot[WIDTH-1]};
        trial_neg = (rem_sh < {1'b0, dvs});
        rem_n     = trial_neg ? rem_sh[WIDTH-1:0] : rem_sh[WIDTH-1:0] - dvs;
        quot_n    = {quot[WIDTH-2:0], ~trial_neg};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            mq     <= '0;
            qm1    <= 1'b0;
            rem    <= '0;
            quot   <= '0;
            dvs    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
`ifdef MULTDIV_DIV0_EXC_EN
            div0_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MULTDIV_DIV0_EXC_EN
            div0_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (multControl) begin
                        state <= MULT;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        mcand <= srcA;
                        acc   <= '0;
                        mq    <= srcB;
                        qm1   <= 1'b0;
                    end else if (divControl) begin
`ifdef MULTDIV_DIV0_EXC_EN
                        if (srcB == '0) begin
                            done   <= 1'b1;
                            div0_r <= 1'b1;
                        end else
`endif
                        begin
                            state  <= DIV;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            rem    <= '0;
                            quot   <= magnitude(srcA);
                            dvs    <= magnitude(srcB);
                            sign_a <= srcA[WIDTH-1];
                            sign_b <= srcB[WIDTH-1];
                        end
                    end
                end
                MULT: begin
                    acc <= acc_n;
                    mq  <= mq_n;
                    qm1 <= mq[0];
                    cnt <= cnt + 6'd1;
                    if (last_iter) begin
                        hi    <= acc_n[WIDTH-1:0];
                        lo    <= mq_n;
                        state <= DONE;
                    end
                end
                DIV: begin
                    rem  <= rem_n;
                    quot <= quot_n;
                    cnt  <= cnt + 6'd1;
                    if (last_iter) state <= FIX;
                end
                FIX: begin
                    lo    <= negate_if(sign_a ^ sign_b, quot);
                    hi    <= negate_if(sign_a, rem);
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
